wb_regfile: RTL and testbench

- Writeback end of the MEM/WB pipeline interface: consumes the registered writeback bundle (two data candidates, destination address, write enable, memtoreg select) and commits it into a 32-entry general-purpose register file.
- Provides the two read ports used by decode, a writeback forwarding tap for the hazard/forwarding unit, and a committed-write counter.
- Sits between the MEM/WB register and ID stage operand fetch.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/wb_mux.sv | 20 ++
 rtl/wb_regfile.sv | 76 +++++++
 tb/tb_wb_regfile.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants and the writeback source encoding.
package cpu_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/wb_mux.sv
// Writeback data select (ALU result vs. load data); also used by the forwarding unit.
module wb_mux
  import cpu_pkg::*;
#(
  parameter int unsigned W = cpu_pkg::DATA_W
) (
  input  logic         memtoreg,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  wb_src_e src;

  always_comb begin
    src = wb_src_e'(memtoreg);
    y   = (src == WB_SRC_MEM) ? d1 : d0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: commit, two async read ports, forwarding tap, write counter.
// Define WB_BYPASS_EN to make read ports write-through for the in-flight writeback.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] regwd0,
  input  logic [DATA_W-1:0] regwd1,
  input  logic [ADDR_W-1:0] regwa,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] wbdata,
  output logic [ADDR_W-1:0] wbaddr,
  output logic              wbvalid,
  output logic [CNT_W-1:0]  wbcount
);

  localparam int unsigned NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  // Entry 0 is not stored; reads of it are forced to zero below.
  logic [DATA_W-1:0] regs [1:NREG-1];

  wb_mux #(.W(DATA_W)) u_wb_mux (
    .memtoreg (memtoreg),
    .d0       (regwd0),
    .d1       (regwd1),
    .y        (wbdata)
  );

  always_comb begin
    wbaddr  = regwa;
    wbvalid = regwrite && (regwa != ZERO_A);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < NREG; i++) regs[i] <= '0;
      wbcount <= '0;
    end else if (wbvalid) begin
      regs[regwa] <= wbdata;
      wbcount     <= wbcount + CNT_W'(1);
    end
  end

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    if (ra0 != ZERO_A) begin
`ifdef WB_BYPASS_EN
      if (wbvalid && (ra0 == regwa)) rd0 = wbdata;
      else                           rd0 = regs[ra0];
`else
      rd0 = regs[ra0];
`endif
    end
    if (ra1 != ZERO_A) begin
`ifdef WB_BYPASS_EN
      if (wbvalid && (ra1 == regwa)) rd1 = wbdata;
      else                           rd1 = regs[ra1];
`else
      rd1 = regs[ra1];
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default and CNT_W=4 instances).
module tb_wb_regfile;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       regwd0, regwd1;
  logic [4:0]        regwa, ra0, ra1;
  logic              regwrite, memtoreg;
  logic [31:0]       rd0, rd1, wbdata;
  logic [4:0]        wbaddr;
  logic              wbvalid;
  logic [31:0]       wbcount;
  logic [31:0]       rd0_s, rd1_s, wbdata_s;
  logic [4:0]        wbaddr_s;
  logic              wbvalid_s;
  logic [3:0]        wbcount_s;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .regwd0(regwd0), .regwd1(regwd1), .regwa(regwa),
    .regwrite(regwrite), .memtoreg(memtoreg), .ra0(ra0), .ra1(ra1),
    .rd0(rd0), .rd1(rd1), .wbdata(wbdata), .wbaddr(wbaddr),
    .wbvalid(wbvalid), .wbcount(wbcount)
  );

  wb_regfile #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .regwd0(regwd0), .regwd1(regwd1), .regwa(regwa),
    .regwrite(regwrite), .memtoreg(memtoreg), .ra0(ra0), .ra1(ra1),
    .rd0(rd0_s), .rd1(rd1_s), .wbdata(wbdata_s), .wbaddr(wbaddr_s),
    .wbvalid(wbvalid_s), .wbcount(wbcount_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; regwd0 = '0; regwd1 = '0; regwa = '0;
    regwrite = 1'b0; memtoreg = 1'b0; ra0 = 5'd5; ra1 = 5'd0;
    #2;
    check_eq("reset_rd0", rd0, 32'h0);
    check_eq("reset_cnt", wbcount, 32'h0);
    tick();
    rst = 1'b0;

    // Preload r5, then reset asynchronously between edges with a write pending
    regwd0 = 32'h1234; regwa = 5'd5; regwrite = 1'b1;
    #1;
    check_eq("preload_wbvalid", {31'b0, wbvalid}, 32'h1);
    check_eq("preload_wbdata", wbdata, 32'h1234);
    tick();
    check_eq("preload_rd0", rd0, 32'h1234);
    check_eq("preload_cnt", wbcount, 32'h1);
    regwd0 = 32'h9999;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_rd0", rd0, 32'h0);
    check_eq("async_rst_cnt", wbcount, 32'h0);
    check_eq("rst_wbaddr", {27'b0, wbaddr}, 32'd5);
    check_eq("rst_wbdata", wbdata, 32'h9999);
    regwrite = 1'bx;
    tick();
    check_eq("rst_x_rd0", rd0, 32'h0);
    check_eq("rst_x_cnt", wbcount, 32'h0);
    regwrite = 1'b0;
    #2 rst = 1'b0;

    // Writeback source select
    regwd0 = 32'hAAAA0000; regwd1 = 32'h5555FFFF; regwa = 5'd3; regwrite = 1'b1;
    memtoreg = 1'b0; ra0 = 5'd3;
    tick();
    check_eq("sel_alu_r3", rd0, 32'hAAAA0000);
    memtoreg = 1'b1;
    #1;
    check_eq("sel_mem_wbdata", wbdata, 32'h5555FFFF);
    tick();
    check_eq("sel_mem_r3", rd0, 32'h5555FFFF);
    check_eq("sel_cnt", wbcount, 32'd2);

    // Register 0 write discarded
    regwa = 5'd0; regwd0 = 32'hFFFFFFFF; memtoreg = 1'b0; ra0 = 5'd0;
    #1;
    check_eq("r0_wbvalid", {31'b0, wbvalid}, 32'h0);
    tick();
    check_eq("r0_rd0", rd0, 32'h0);
    check_eq("r0_cnt", wbcount, 32'd2);

    // Same-cycle read/write on r7
    regwa = 5'd7; regwd0 = 32'h11;
    tick();
    regwd0 = 32'h22; ra0 = 5'd7; ra1 = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check_eq("rw_same_pre", rd1, 32'h22);
`else
    check_eq("rw_same_pre", rd1, 32'h11);
`endif
    tick();
    check_eq("rw_same_post_rd1", rd1, 32'h22);
    check_eq("rw_same_post_rd0", rd0, 32'h22);
    check_eq("rw_cnt", wbcount, 32'd4);

    // regwrite low: no commit
    regwrite = 1'b0; regwa = 5'd9; regwd0 = 32'hDEAD; ra0 = 5'd9;
    #1;
    check_eq("nowr_wbaddr", {27'b0, wbaddr}, 32'd9);
    check_eq("nowr_wbvalid", {31'b0, wbvalid}, 32'h0);
    tick();
    check_eq("nowr_r9", rd0, 32'h0);
    check_eq("nowr_cnt", wbcount, 32'd4);
    check_eq("c4_cnt_before", {28'b0, wbcount_s}, 32'd4);

    // Counter wrap: 17 writes after reset -> 4-bit counter reads 1
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    regwrite = 1'b1; regwa = 5'd1; ra1 = 5'd1;
    for (int i = 1; i <= 17; i++) begin
      regwd0 = 32'(i);
      tick();
    end
    check_eq("wrap_c4", {28'b0, wbcount_s}, 32'd1);
    check_eq("wrap_c32", wbcount, 32'd17);
    check_eq("wrap_r1", rd1, 32'd17);
    regwrite = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
